// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: sequential PC generation, credit-limited imem reads,
// and a DEPTH-entry FIFO of {pc, instruction}. Redirects flush the FIFO and drain in-flight responses.
module instr_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_READY,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        OUT_VALID,
    output logic [31:0] OUT_INSTRUCTION,
    output logic [31:0] OUT_PC,
    input  logic        DEC_READY
);
    localparam int CW    = $clog2(DEPTH);
    localparam int CNT_W = CW + 1;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]       state;
    logic [31:0]      fetch_pc;
    logic [31:0]      rsp_pc;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] stale;
    logic [CNT_W-1:0] count;
    logic [CW-1:0]    wr_ptr;
    logic [CW-1:0]    rd_ptr;
    logic [31:0]      mem_instr [DEPTH];
    logic [31:0]      mem_pc    [DEPTH];

    logic             credit_ok;
    logic             issue;
    logic             rsp;
    logic             push;
    logic             pop;
    logic [31:0]      redir_pc;
    logic [CNT_W-1:0] inflight_nxt;

    // Queued entries plus outstanding reads never exceed DEPTH, so a push always has a slot.
    assign credit_ok    = ({1'b0, count} + {1'b0, inflight}) < (CNT_W+1)'(DEPTH);
    assign IMEM_REQ     = (state == ST_FETCH) && credit_ok;
    assign IMEM_ADDR    = fetch_pc;
    assign issue        = IMEM_REQ && IMEM_READY;
    assign rsp          = IMEM_RVALID && (inflight != '0);
    assign push         = rsp && (state == ST_FETCH) && !REDIRECT;
    assign pop          = OUT_VALID && DEC_READY;
    assign redir_pc     = REDIRECT_PC & ~32'd3;
    assign inflight_nxt = inflight + CNT_W'(issue) - CNT_W'(rsp);

    assign OUT_VALID       = (count != '0);
    assign OUT_INSTRUCTION = OUT_VALID ? mem_instr[rd_ptr] : '0;
    assign OUT_PC          = OUT_VALID ? mem_pc[rd_ptr]    : '0;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state    <= ST_BOOT;
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            stale    <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= inflight_nxt;
            case (state)
                ST_BOOT: state <= ST_FETCH;
                ST_FETCH: begin
                    if (REDIRECT) begin
                        // Everything still outstanding (incl. a same-cycle issue) becomes stale.
                        fetch_pc <= redir_pc;
                        rsp_pc   <= redir_pc;
                        count    <= '0;
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        stale    <= inflight_nxt;
                        if (inflight_nxt != '0) state <= ST_FLUSH;
                    end else begin
                        if (issue) fetch_pc <= fetch_pc + 32'd4;
                        if (push) begin
                            wr_ptr <= wr_ptr + 1'b1;
                            rsp_pc <= rsp_pc + 32'd4;
                        end
                        if (pop) rd_ptr <= rd_ptr + 1'b1;
                        count <= count + CNT_W'(push) - CNT_W'(pop);
                    end
                end
                ST_FLUSH: begin
                    if (REDIRECT) begin
                        fetch_pc <= redir_pc;
                        rsp_pc   <= redir_pc;
                    end
                    if (rsp) begin
                        stale <= stale - 1'b1;
                        if (stale == CNT_W'(1)) state <= ST_FETCH;
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_instr[wr_ptr] <= IMEM_RDATA;
            mem_pc[wr_ptr]    <= rsp_pc;
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue: in-order memory model with random latency,
// queue-based reference of delivered instructions, plus a wrap/reset check on a second instance.
module tb_instr_fetch_queue;
    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    // main instance, RESET_PC = 0
    logic        RESET_N = 1'b0;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_READY = 1'b0;
    logic        IMEM_RVALID = 1'b0;
    logic [31:0] IMEM_RDATA = '0;
    logic        REDIRECT = 1'b0;
    logic [31:0] REDIRECT_PC = '0;
    logic        OUT_VALID;
    logic [31:0] OUT_INSTRUCTION;
    logic [31:0] OUT_PC;
    logic        DEC_READY = 1'b0;

    // wrap instance, RESET_PC = FFFF_FFF8
    logic        rst_n1 = 1'b0;
    logic        req1;
    logic [31:0] addr1;
    logic        rvalid1 = 1'b0;
    logic [31:0] rdata1 = '0;
    logic        ovld1;
    logic [31:0] oins1;
    logic [31:0] opc1;

    instr_fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_READY(IMEM_READY), .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
        .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC), .OUT_VALID(OUT_VALID),
        .OUT_INSTRUCTION(OUT_INSTRUCTION), .OUT_PC(OUT_PC), .DEC_READY(DEC_READY)
    );

    instr_fetch_queue #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
        .CLK(CLK), .RESET_N(rst_n1), .IMEM_REQ(req1), .IMEM_ADDR(addr1),
        .IMEM_READY(1'b1), .IMEM_RVALID(rvalid1), .IMEM_RDATA(rdata1),
        .REDIRECT(1'b0), .REDIRECT_PC(32'h0), .OUT_VALID(ovld1),
        .OUT_INSTRUCTION(oins1), .OUT_PC(opc1), .DEC_READY(1'b0)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Reference model: memory request queue, delivered-instruction queue, stale drain count
    typedef struct {
        logic [31:0] addr;
        int          cyc;
    } req_t;
    req_t        mq[$];
    logic [31:0] mfifo[$];
    int          stale_exp = 0;
    logic [31:0] exp_issue = 32'h0;
    int          cyc = 0;

    task automatic do_reset();
        @(negedge CLK);
        RESET_N = 1'b0; REDIRECT = 1'b0; IMEM_RVALID = 1'b0; DEC_READY = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        chk("rst_req",  32'(IMEM_REQ), 32'd0);
        chk("rst_addr", IMEM_ADDR, 32'h0);
        chk("rst_ovld", 32'(OUT_VALID), 32'd0);
        chk("rst_oins", OUT_INSTRUCTION, 32'h0);
        chk("rst_opc",  OUT_PC, 32'h0);
        mq.delete();
        mfifo.delete();
        stale_exp = 0;
        exp_issue = 32'h0;
    endtask

    // One clock cycle: drive at negedge, check, then advance the model to post-edge state.
    task automatic step(input int p_rdy, input int p_rv, input int p_dec, input int p_redir,
                        input int tsel);
        logic        rv, issue, pop, flushing, exp_req;
        logic [31:0] raddr, tgt;
        int          sel;
        req_t        nr;
        @(negedge CLK);
        cyc++;
        IMEM_READY  = ($urandom_range(99) < p_rdy);
        rv          = (mq.size() > 0) && (mq[0].cyc < cyc) && ($urandom_range(99) < p_rv);
        IMEM_RVALID = rv;
        IMEM_RDATA  = rv ? word_of(mq[0].addr) : $urandom;
        DEC_READY   = ($urandom_range(99) < p_dec);
        REDIRECT    = ($urandom_range(99) < p_redir);
        sel = (tsel < 0) ? int'($urandom_range(2)) : tsel;
        tgt = (sel == 0) ? 32'h0000_1002 : (sel == 1) ? 32'h0000_0200 : $urandom;
        REDIRECT_PC = tgt;
        #1;
        flushing = (stale_exp > 0);
        exp_req  = !flushing && ((mfifo.size() + mq.size()) < 4);
        chk("req", 32'(IMEM_REQ), 32'(exp_req));
        if (exp_req) chk("addr", IMEM_ADDR, exp_issue);
        chk("ovld", 32'(OUT_VALID), 32'(mfifo.size() != 0));
        if (mfifo.size() != 0) begin
            chk("opc", OUT_PC, mfifo[0]);
            chk("oins", OUT_INSTRUCTION, word_of(mfifo[0]));
        end
        issue = exp_req && IMEM_READY;
        pop   = (mfifo.size() != 0) && DEC_READY;
        raddr = '0;
        if (rv) begin
            raddr = mq[0].addr;
            void'(mq.pop_front());
        end
        if (issue) begin
            nr.addr = exp_issue;
            nr.cyc  = cyc;
            mq.push_back(nr);
        end
        if (flushing) begin
            if (rv) stale_exp--;
            if (REDIRECT) exp_issue = tgt & ~32'd3;
        end else if (REDIRECT) begin
            mfifo.delete();
            stale_exp = mq.size();
            exp_issue = tgt & ~32'd3;
        end else begin
            if (pop) void'(mfifo.pop_front());
            if (rv) mfifo.push_back(raddr);
            if (issue) exp_issue += 32'd4;
        end
    endtask

    initial begin
        do_reset();
        // sequential fetch with 1-cycle memory
        repeat (12) step(100, 100, 100, 0, -1);
        // decoder stalled: fill to DEPTH and stop requesting
        repeat (15) step(100, 100, 0, 0, -1);
        // full FIFO with simultaneous push and pop
        repeat (12) step(100, 100, 100, 0, -1);

        // two in flight then redirect to an unaligned target
        do_reset();
        repeat (2) step(100, 0, 0, 0, -1);
        step(0, 0, 0, 100, 0);
        repeat (4) step(0, 100, 0, 0, -1);
        repeat (8) step(100, 100, 100, 0, -1);

        // redirect again while flushing
        do_reset();
        repeat (3) step(100, 0, 0, 0, -1);
        step(0, 0, 0, 100, 0);
        step(0, 0, 0, 100, 1);
        repeat (5) step(0, 100, 0, 0, -1);
        repeat (8) step(100, 100, 100, 0, -1);

        // random traffic with a reset in the middle
        for (int i = 0; i < 1600; i++) begin
            if (i == 800) do_reset();
            step(70, 60, 60, 4, -1);
        end

        // wrap-around and mid-run reset on the second instance
        @(negedge CLK);
        rst_n1 = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        rst_n1 = 1'b1;
        #1;
        chk("w_boot_req", 32'(req1), 32'd0);
        chk("w_boot_addr", addr1, 32'hFFFF_FFF8);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            #1;
            chk("w_req", 32'(req1), 32'd1);
            chk("w_addr", addr1, 32'hFFFF_FFF8 + 32'(4 * k));
        end
        @(negedge CLK);
        #1;
        chk("w_credit", 32'(req1), 32'd0);
        rvalid1 = 1'b1;
        rdata1  = 32'hCAFE_0013;
        @(negedge CLK);
        rvalid1 = 1'b0;
        #1;
        chk("w_ovld", 32'(ovld1), 32'd1);
        chk("w_opc", opc1, 32'hFFFF_FFF8);
        chk("w_oins", oins1, 32'hCAFE_0013);
        rst_n1 = 1'b0;
        @(posedge CLK);
        #1;
        chk("w_rst_ovld", 32'(ovld1), 32'd0);
        chk("w_rst_addr", addr1, 32'hFFFF_FFF8);
        @(negedge CLK);
        rst_n1 = 1'b1;
        @(negedge CLK);
        #1;
        chk("w_restart_req", 32'(req1), 32'd1);
        chk("w_restart_addr", addr1, 32'hFFFF_FFF8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
